// File: rtl/tx_frame_serializer.sv
// UART-style transmit framing stage. Takes one byte per frame over a
// valid/ready handshake. It sends a start bit, eight data bits LSB-first, an
// optional parity bit and one or two stop bits. Every bit boundary lines up
// with the wrap of the upstream clock_generator phase counter.
module tx_frame_serializer #(
    parameter int MOD        = 8,
    parameter int BITS       = $clog2(MOD),
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0,
    parameter int STOP_BITS  = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [BITS-1:0] count,
    input  logic [7:0]      data_in,
    input  logic            data_valid,
    output logic            data_ready,
    output logic            tx_out,
    output logic            tx_busy,
    output logic            bit_strobe
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic        stopcnt_q, stopcnt_d;
    logic        parity_q, parity_d;
    logic        tx_q, tx_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        strobe_q, strobe_d;
    logic        tick;

    // The last phase of the generator period. Each new bit appears on the edge after it.
    assign tick = (count == BITS'(MOD - 1));

    // Next-state and next-output logic for the framing FSM.
    always_comb begin
        // NOTE: every variable gets its default first. Then no path through the
        // case can leave a variable unassigned, so no latch is inferred.
        state_d   = state_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        stopcnt_d = stopcnt_q;
        parity_d  = parity_q;
        tx_d      = tx_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        strobe_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // Accepting a byte does not wait for tick. WAIT handles the alignment.
                if (data_valid && ready_q) begin
                    shreg_d  = data_in;
                    parity_d = (^data_in) ^ PARITY_ODD;
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (tick) begin
                    tx_d     = 1'b0;
                    strobe_d = 1'b1;
                    state_d  = START;
                end
            end
            START: begin
                if (tick) begin
                    tx_d     = shreg_q[0];
                    shreg_d  = {1'b0, shreg_q[7:1]};
                    bitcnt_d = 3'd0;
                    strobe_d = 1'b1;
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    strobe_d = 1'b1;
                    if (bitcnt_q != 3'd7) begin
                        tx_d     = shreg_q[0];
                        shreg_d  = {1'b0, shreg_q[7:1]};
                        bitcnt_d = bitcnt_q + 3'd1;
                    end else if (PARITY_EN) begin
                        tx_d    = parity_q;
                        state_d = PARITY;
                    end else begin
                        tx_d      = 1'b1;
                        stopcnt_d = 1'b0;
                        state_d   = STOP;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    tx_d      = 1'b1;
                    strobe_d  = 1'b1;
                    stopcnt_d = 1'b0;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    if (int'(stopcnt_q) == STOP_BITS - 1) begin
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        // A second stop bit starts here. The line is already high.
                        stopcnt_d = 1'b1;
                        strobe_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers. A synchronous reset aborts any frame in flight.
    always_ff @(posedge clock) begin
        // NOTE: use non-blocking assignments here. Then every register samples
        // the values from before the edge, whatever the statement order.
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= 8'd0;
            bitcnt_q  <= 3'd0;
            stopcnt_q <= 1'b0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            strobe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            stopcnt_q <= stopcnt_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            strobe_q  <= strobe_d;
        end
    end

    assign data_ready = ready_q;
    assign tx_out     = tx_q;
    assign tx_busy    = busy_q;
    assign bit_strobe = strobe_q;

endmodule

// File: tb/tb_tx_frame_serializer.sv
// Directed bench for tx_frame_serializer. There are three instances: no
// parity, even parity and odd parity. They share one phase generator, and
// one stimulus/monitor port is steered by sel.
module tb_tx_frame_serializer;

    localparam int MOD = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       gen_rst = 1'b1;
    logic       cnt_en = 1'b1;
    logic [2:0] count;
    logic [7:0] data = 8'd0;
    logic       valid = 1'b0;
    int         sel = 0;

    logic [2:0] rdy, txo, busy, stb;
    logic       mon_ready, mon_tx, mon_busy, mon_stb;

    int passed = 0;
    int total  = 0;

    always #10 clk = ~clk;

    // Stand-in for clock_generator: a free-running mod-MOD counter that can be frozen.
    always @(posedge clk) begin
        if (gen_rst)     count <= 3'd0;
        else if (cnt_en) count <= (count == 3'(MOD - 1)) ? 3'd0 : count + 3'd1;
    end

    tx_frame_serializer #(.MOD(MOD)) dut_np (
        .clock(clk), .reset(rst), .count(count), .data_in(data),
        .data_valid(valid && (sel == 0)), .data_ready(rdy[0]),
        .tx_out(txo[0]), .tx_busy(busy[0]), .bit_strobe(stb[0])
    );

    tx_frame_serializer #(.MOD(MOD), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_pe (
        .clock(clk), .reset(rst), .count(count), .data_in(data),
        .data_valid(valid && (sel == 1)), .data_ready(rdy[1]),
        .tx_out(txo[1]), .tx_busy(busy[1]), .bit_strobe(stb[1])
    );

    tx_frame_serializer #(.MOD(MOD), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut_po (
        .clock(clk), .reset(rst), .count(count), .data_in(data),
        .data_valid(valid && (sel == 2)), .data_ready(rdy[2]),
        .tx_out(txo[2]), .tx_busy(busy[2]), .bit_strobe(stb[2])
    );

    always_comb begin
        mon_ready = rdy[sel];
        mon_tx    = txo[sel];
        mon_busy  = busy[sel];
        mon_stb   = stb[sel];
    end

    // Present a byte and wait for the handshake to complete.
    task automatic accept(input logic [7:0] b, input bit hold);
        bit ok = 0;
        @(negedge clk);
        data  = b;
        valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (!mon_ready) begin
                ok = 1;
                break;
            end
        end
        if (!hold) valid = 1'b0;
        total++;
        if (ok && mon_busy === 1'b1) passed++;
        else $display("FAIL accept_%02h: ready=%b busy=%b, required ready=0 busy=1", b, mon_ready, mon_busy);
    endtask

    // Follow one whole frame clock by clock, from the start-bit strobe to the return to IDLE.
    task automatic expect_frame(input string name, input logic [7:0] b, input bit has_par, input logic pbit);
        logic exp_bits [0:10];
        int   n;
        bit   found = 0;
        bit   line_ok = 1;
        bit   width_ok;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[i+1] = b[i];
        n = 9;
        if (has_par) begin
            exp_bits[9] = pbit;
            n = 10;
        end
        exp_bits[n] = 1'b1;
        n++;

        for (int i = 0; i < MOD + 1; i++) begin
            @(negedge clk);
            if (mon_stb === 1'b1) begin
                found = 1;
                break;
            end
            if (mon_tx !== 1'b1) line_ok = 0;
        end
        total++;
        if (found && line_ok) passed++;
        else $display("FAIL %s_start: strobe_seen=%0d line_high=%0d, required 1 1", name, found, line_ok);
        if (!found) return;

        for (int k = 0; k < n; k++) begin
            total++;
            if (mon_tx === exp_bits[k]) passed++;
            else $display("FAIL %s_bit%0d: tx_out=%b, required %b", name, k, mon_tx, exp_bits[k]);
            width_ok = 1;
            for (int c = 1; c < MOD; c++) begin
                @(negedge clk);
                if (mon_stb !== 1'b0 || mon_tx !== exp_bits[k]) width_ok = 0;
            end
            @(negedge clk);
            if (k < n - 1 && mon_stb !== 1'b1) width_ok = 0;
            total++;
            if (width_ok) passed++;
            else $display("FAIL %s_width%0d: bit not exactly %0d clocks (strobe=%b), required exact width", name, k, MOD, mon_stb);
        end

        total++;
        if (mon_ready === 1'b1 && mon_busy === 1'b0 && mon_tx === 1'b1 && mon_stb === 1'b0) passed++;
        else $display("FAIL %s_end: ready=%b busy=%b tx=%b strobe=%b, required 1 0 1 0",
                      name, mon_ready, mon_busy, mon_tx, mon_stb);
    endtask

    task automatic test_reset();
        bit quiet = 1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (mon_tx === 1'b1 && mon_ready === 1'b1 && mon_busy === 1'b0 && mon_stb === 1'b0) passed++;
        else $display("FAIL reset: tx=%b ready=%b busy=%b strobe=%b, required 1 1 0 0",
                      mon_tx, mon_ready, mon_busy, mon_stb);
        rst     = 1'b0;
        gen_rst = 1'b0;
        for (int i = 0; i < 3 * MOD; i++) begin
            @(negedge clk);
            if (stb !== 3'b000 || txo !== 3'b111 || rdy !== 3'b111) quiet = 0;
        end
        total++;
        if (quiet) passed++;
        else $display("FAIL idle_quiet: strobe=%b tx=%b ready=%b, required 000 111 111", stb, txo, rdy);
    endtask

    task automatic test_basic();
        sel = 0;
        accept(8'hA5, 0);
        expect_frame("a5", 8'hA5, 0, 1'b0);
    endtask

    task automatic test_parity();
        sel = 1;
        accept(8'h07, 0);
        expect_frame("even07", 8'h07, 1, 1'b1);
        sel = 2;
        accept(8'h07, 0);
        expect_frame("odd07", 8'h07, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        sel = 0;
        accept(8'h3C, 1);
        data = 8'hC3;
        expect_frame("b2b_3c", 8'h3C, 0, 1'b0);
        expect_frame("b2b_c3", 8'hC3, 0, 1'b0);
        valid = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int nstb = 0;
        sel = 0;
        accept(8'hFF, 0);
        for (int i = 0; i < 8 * MOD && nstb < 5; i++) begin
            @(negedge clk);
            if (mon_stb === 1'b1) nstb++;
        end
        repeat (2) @(negedge clk);
        total++;
        if (nstb == 5 && mon_busy === 1'b1) passed++;
        else $display("FAIL midreset_pre: strobes=%0d busy=%b, required 5 1", nstb, mon_busy);
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (mon_tx === 1'b1 && mon_ready === 1'b1 && mon_busy === 1'b0 && mon_stb === 1'b0) passed++;
        else $display("FAIL midreset: tx=%b ready=%b busy=%b strobe=%b, required 1 1 0 0",
                      mon_tx, mon_ready, mon_busy, mon_stb);
        rst = 1'b0;
        accept(8'h81, 0);
        expect_frame("after_rst81", 8'h81, 0, 1'b0);
    endtask

    task automatic test_ignore_inputs();
        sel = 0;
        accept(8'h5A, 0);
        fork
            expect_frame("noise5a", 8'h5A, 0, 1'b0);
            begin
                repeat (60) begin
                    @(negedge clk);
                    #2;
                    data  = 8'($urandom);
                    valid = ~valid;
                end
                valid = 1'b0;
            end
        join
    endtask

    task automatic test_stalled_count();
        bit held = 1;
        sel = 0;
        for (int i = 0; i < 2 * MOD; i++) begin
            @(negedge clk);
            if (count == 3'd3) break;
        end
        cnt_en = 1'b0;
        accept(8'h96, 0);
        for (int i = 0; i < 3 * MOD; i++) begin
            @(negedge clk);
            if (mon_tx !== 1'b1 || mon_busy !== 1'b1 || mon_stb !== 1'b0) held = 0;
        end
        total++;
        if (held) passed++;
        else $display("FAIL stall_wait: tx=%b busy=%b strobe=%b, required 1 1 0", mon_tx, mon_busy, mon_stb);
        cnt_en = 1'b1;
        expect_frame("stall96", 8'h96, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_reset_mid_frame();
        test_ignore_inputs();
        test_stalled_count();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
